regfile_wb: RTL and testbench

Write side of the 32 x 8-bit general register file.
- Owns the register array and drives the flattened 256-bit image read by the ALU source muxes. Register n occupies bits [8n+7:8n].
- Commits ALU results directly.
- Commits memory load data through a 2-entry buffered valid/ready port.
- Keeps a per-register load-pending scoreboard so a younger ALU write is never overwritten by an older load.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_wb_fifo.sv | 54 +++++
 rtl/regfile_wb.sv | 104 ++++++++++
 tb/tb_regfile_wb.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and the write-back buffer entry type for the register-file
// write side.
package regfile_pkg;
   localparam int REG_W = 8;
   localparam int NREGS = 32;
   localparam int IDX_W = 5;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [REG_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/regfile_wb_fifo.sv
// Two-entry synchronous FIFO holding memory write-backs until the array
// write port is free.
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  wb_entry_t  din,
   output wb_entry_t  head,
   output logic       full,
   output logic       empty,
   output logic [1:0] count
);

   wb_entry_t  mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] cnt;
   logic       push_ok;
   logic       pop_ok;

   assign full    = (cnt == 2'(DEPTH));
   assign empty   = (cnt == 2'd0);
   assign count   = cnt;
   assign head    = mem[rd_ptr];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push_ok) wr_ptr <= ~wr_ptr;
         if (pop_ok)  rd_ptr <= ~rd_ptr;
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Payload storage carries no reset; validity is tracked by cnt alone.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/regfile_wb.sv
// Write side of the general register file: ALU commits, buffered load
// write-backs, and a load-pending scoreboard that protects younger ALU writes.
module regfile_wb #(
   parameter int REG_W      = 8,
   parameter int NREGS      = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          alu_we,
   input  logic [regfile_pkg::IDX_W-1:0] alu_dst,
   input  logic [REG_W-1:0]              alu_result,
   input  logic                          ld_issue,
   input  logic [regfile_pkg::IDX_W-1:0] ld_dst,
   input  logic                          mem_valid,
   output logic                          mem_ready,
   input  logic [regfile_pkg::IDX_W-1:0] mem_dst,
   input  logic [REG_W-1:0]              mem_data,
   output logic [NREGS*REG_W-1:0]        regfile,
   output logic [NREGS-1:0]              busy,
   output logic                          wb_pending
);
   import regfile_pkg::*;

   logic [REG_W-1:0] regs [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;
   logic [NREGS-1:0] kill_q, kill_d;

   wb_entry_t        wb_in;
   wb_entry_t        head;
   logic             full, empty;
   logic [1:0]       count;
   logic             pop;

   logic             we;
   logic [IDX_W-1:0] wdst;
   logic [REG_W-1:0] wdata;

   assign wb_in.idx  = mem_dst;
   assign wb_in.data = mem_data;

   // The ALU owns the single write port whenever it writes; the buffer drains otherwise.
   assign pop = !empty && !alu_we;

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (mem_valid),
      .pop   (pop),
      .din   (wb_in),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign mem_ready  = !full;
   assign wb_pending = (count != 2'd0);
   assign busy       = busy_q;

   // Later assignments win: a same-cycle ld_issue overrides both the ALU kill and the dequeue clear.
   always_comb begin
      busy_d = busy_q;
      kill_d = kill_q;
      if (alu_we && busy_q[alu_dst]) kill_d[alu_dst] = 1'b1;
      if (pop) begin
         busy_d[head.idx] = 1'b0;
         kill_d[head.idx] = 1'b0;
      end
      if (ld_issue) begin
         busy_d[ld_dst] = 1'b1;
         kill_d[ld_dst] = 1'b0;
      end
   end

   always_comb begin
      we    = alu_we || (pop && !kill_q[head.idx]);
      wdst  = alu_we ? alu_dst : head.idx;
      wdata = alu_we ? alu_result : head.data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         kill_q <= '0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         busy_q <= busy_d;
         kill_q <= kill_d;
         if (we) regs[wdst] <= wdata;
      end
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_image
      assign regfile[g*REG_W +: REG_W] = regs[g];
   end

   a_ld_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
      ld_issue |-> (!busy_q[ld_dst] || (pop && head.idx == ld_dst)));

   a_wb_busy: assert property (@(posedge clk) disable iff (!rst_n)
      pop |-> busy_q[head.idx]);

endmodule

// File: tb/tb_regfile_wb.sv
// Randomized and directed bench for regfile_wb against a queue-based
// reference model of the register file and load scoreboard.
module tb_regfile_wb;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         alu_we;
   logic [4:0]   alu_dst;
   logic [7:0]   alu_result;
   logic         ld_issue;
   logic [4:0]   ld_dst;
   logic         mem_valid;
   logic         mem_ready;
   logic [4:0]   mem_dst;
   logic [7:0]   mem_data;
   logic [255:0] regfile;
   logic [31:0]  busy;
   logic         wb_pending;

   always #5 clk = ~clk;

   regfile_wb dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alu_we     (alu_we),
      .alu_dst    (alu_dst),
      .alu_result (alu_result),
      .ld_issue   (ld_issue),
      .ld_dst     (ld_dst),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_dst    (mem_dst),
      .mem_data   (mem_data),
      .regfile    (regfile),
      .busy       (busy),
      .wb_pending (wb_pending)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: plain arrays for registers/scoreboard, a queue for the buffer.
   typedef struct {
      int         idx;
      logic [7:0] data;
   } ent_t;

   logic [7:0] m_reg  [32];
   bit         m_busy [32];
   bit         m_kill [32];
   ent_t       m_q    [$];

   function automatic void m_reset();
      for (int i = 0; i < 32; i++) begin
         m_reg[i]  = 8'h00;
         m_busy[i] = 1'b0;
         m_kill[i] = 1'b0;
      end
      m_q.delete();
   endfunction

   function automatic logic [255:0] m_image();
      logic [255:0] v;
      for (int i = 0; i < 32; i++) v[i*8 +: 8] = m_reg[i];
      return v;
   endfunction

   function automatic logic [31:0] m_busyv();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic idle();
      alu_we = 0; alu_dst = 0; alu_result = 0;
      ld_issue = 0; ld_dst = 0;
      mem_valid = 0; mem_dst = 0; mem_data = 0;
   endtask

   // One clock with the currently driven inputs; updates the model and compares.
   task automatic step(output bit acc);
      bit   deq;
      ent_t e;
      acc = mem_valid && (m_q.size() < 2);
      deq = !alu_we && (m_q.size() > 0);
      @(posedge clk);
      if (alu_we) begin
         if (m_busy[alu_dst] && !(ld_issue && ld_dst == alu_dst)) m_kill[alu_dst] = 1'b1;
         m_reg[alu_dst] = alu_result;
      end
      if (deq) begin
         e = m_q.pop_front();
         if (!m_kill[e.idx]) m_reg[e.idx] = e.data;
         m_busy[e.idx] = 1'b0;
         m_kill[e.idx] = 1'b0;
      end
      if (ld_issue) begin
         m_busy[ld_dst] = 1'b1;
         m_kill[ld_dst] = 1'b0;
      end
      if (acc) m_q.push_back('{idx: int'(mem_dst), data: mem_data});
      @(negedge clk);
      chk("image", regfile, m_image());
      chk("busy", busy, m_busyv());
      chk("mem_ready", mem_ready, m_q.size() < 2);
      chk("wb_pending", wb_pending, m_q.size() > 0);
   endtask

   task automatic step0();
      bit a;
      step(a);
   endtask

   initial begin
      bit         acc;
      int         accepts;
      int         nxt;
      logic [7:0] d3 [3];
      int         iss [$];
      bit         offering;

      idle();
      m_reset();
      rst_n = 1'b0;
      #12;
      chk("rst_image", regfile, 256'h0);
      chk("rst_busy", busy, 32'h0);
      chk("rst_ready", mem_ready, 1'b1);
      chk("rst_pend", wb_pending, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU write, 1-cycle latency
      alu_we = 1; alu_dst = 5; alu_result = 8'hA7;
      step0();
      chk("t1_r5", regfile[47:40], 8'hA7);
      idle();

      // Load commit
      ld_issue = 1; ld_dst = 3;
      step0();
      idle();
      step0();
      mem_valid = 1; mem_dst = 3; mem_data = 8'h3C;
      step0();
      idle();
      chk("t2_busy_before", busy[3], 1'b1);
      chk("t2_r3_before", regfile[31:24], 8'h00);
      step0();
      chk("t2_r3", regfile[31:24], 8'h3C);
      chk("t2_busy_after", busy[3], 1'b0);
      chk("t2_pend", wb_pending, 1'b0);

      // Back-pressure with the ALU holding the write port
      for (int i = 0; i < 3; i++) begin
         d3[i] = 8'($urandom_range(1, 255));
         ld_issue = 1; ld_dst = 5'(10 + i);
         step0();
      end
      idle();
      accepts = 0;
      nxt = 0;
      for (int c = 0; c < 6; c++) begin
         alu_we = 1; alu_dst = 20; alu_result = 8'($urandom);
         mem_valid = (nxt < 3); mem_dst = 5'(10 + nxt); mem_data = d3[nxt % 3];
         step(acc);
         if (acc) begin accepts++; nxt++; end
      end
      chk("t3_accepts", accepts, 2);
      chk("t3_ready_low", mem_ready, 1'b0);
      alu_we = 0;
      step(acc);
      if (acc) nxt++;
      chk("t3_r10", regfile[87:80], d3[0]);
      chk("t3_r11_not_yet", regfile[95:88], 8'h00);
      for (int c = 0; c < 5; c++) begin
         mem_valid = (nxt < 3); mem_dst = 5'(10 + nxt); mem_data = d3[nxt % 3];
         step(acc);
         if (acc) nxt++;
      end
      idle();
      chk("t3_r11", regfile[95:88], d3[1]);
      chk("t3_r12", regfile[103:96], d3[2]);
      chk("t3_drained", wb_pending, 1'b0);

      // WAW kill
      ld_issue = 1; ld_dst = 7;
      step0();
      idle();
      alu_we = 1; alu_dst = 7; alu_result = 8'h11;
      step0();
      idle();
      mem_valid = 1; mem_dst = 7; mem_data = 8'hFF;
      step0();
      idle();
      step0();
      chk("t4_r7", regfile[63:56], 8'h11);
      chk("t4_busy7", busy[7], 1'b0);
      ld_issue = 1; ld_dst = 7;
      step0();
      idle();
      mem_valid = 1; mem_dst = 7; mem_data = 8'h5A;
      step0();
      idle();
      step0();
      chk("t4_kill_cleared", regfile[63:56], 8'h5A);

      // Same-cycle ld_issue + ALU write to one register
      ld_issue = 1; ld_dst = 9; alu_we = 1; alu_dst = 9; alu_result = 8'h22;
      step0();
      idle();
      chk("t5_r9_alu", regfile[79:72], 8'h22);
      chk("t5_busy9", busy[9], 1'b1);
      mem_valid = 1; mem_dst = 9; mem_data = 8'h44;
      step0();
      idle();
      step0();
      chk("t5_r9_load", regfile[79:72], 8'h44);

      // Randomized traffic, legal by construction
      offering = 0;
      for (int c = 0; c < 600; c++) begin
         bit deq;
         int r;
         alu_we     = ($urandom_range(0, 9) < 4);
         alu_dst    = 5'($urandom);
         alu_result = 8'($urandom);
         if (!offering && iss.size() > 0 && $urandom_range(0, 1) == 1) begin
            int k;
            k = $urandom_range(0, iss.size() - 1);
            mem_dst  = 5'(iss[k]);
            mem_data = 8'($urandom);
            iss.delete(k);
            offering = 1;
         end
         mem_valid = offering;
         deq = !alu_we && (m_q.size() > 0);
         ld_issue = 0;
         if ($urandom_range(0, 9) < 3) begin
            if (deq && $urandom_range(0, 2) == 0) r = m_q[0].idx;
            else r = $urandom_range(0, 31);
            if (!m_busy[r] || (deq && m_q[0].idx == r)) begin
               ld_issue = 1;
               ld_dst   = 5'(r);
               iss.push_back(r);
            end
         end
         step(acc);
         if (acc) offering = 0;
      end
      idle();

      // Reset mid-operation with a full buffer
      for (int c = 0; c < 4; c++) step0();
      m_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      @(negedge clk);
      ld_issue = 1; ld_dst = 3;
      step0();
      ld_dst = 4;
      step0();
      idle();
      alu_we = 1; alu_dst = 0; alu_result = 8'h01;
      mem_valid = 1; mem_dst = 3; mem_data = 8'hC3;
      step0();
      mem_dst = 4; mem_data = 8'hC4;
      step0();
      mem_valid = 0;
      chk("t6_full", mem_ready, 1'b0);
      chk("t6_busy3", busy[3], 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_image", regfile, 256'h0);
      chk("t6_busy", busy, 32'h0);
      chk("t6_ready", mem_ready, 1'b1);
      chk("t6_pend", wb_pending, 1'b0);
      m_reset();
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) step0();
      chk("t6_no_commit", regfile, 256'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
